mpsoc_memory_stream_loader: RTL and testbench
=============================================

// Module: mpsoc_memory_stream_loader
// PURPOSE
//  Upstream fill stage for the MPSoC single-port on-chip RAM. A CPU programs a start word
//  address and a length through a small Avalon-MM control slave, then sets GO. The block
//  accepts 32-bit words on a valid/ready stream sink and writes each one, in order, to
//  consecutive RAM word addresses through the RAM's s1-style port. It raises done/irq when
//  the transfer completes.
// PARAMETERS
//  ADDR_W   15     RAM word-address width (mem_address width)
//  DEPTH    25600  RAM depth in 32-bit words; legal range for START+LENGTH
//  DATA_W   32     Stream and RAM data width (fixed at 32, byteenable is 4 bits)
// PORTS
//  clk             in   1       single clock for all logic
//  reset_n         in   1       asynchronous active-low reset
//  ctl_address     in   2       control register word index
//  ctl_read        in   1       control read strobe
//  ctl_write       in   1       control write strobe
//  ctl_writedata   in   32      control write data
//  ctl_readdata    out  32      control read data, valid 1 cycle after ctl_read
//  snk_data        in   32      stream word
//  snk_valid       in   1       stream word valid
//  snk_ready       out  1       loader can accept a word this cycle
//  mem_address     out  ADDR_W  RAM word address
//  mem_byteenable  out  4       RAM byte enables
//  mem_chipselect  out  1       RAM chipselect
//  mem_write       out  1       RAM write strobe
//  mem_writedata   out  32      RAM write data
//  mem_clken       out  1       RAM clock enable
//  irq             out  1       level interrupt = done & irq_en
// BEHAVIOUR
//  Registers (word index):
//   0 START  [ADDR_W-1:0] first word address
//   1 LENGTH [15:0] word count
//   2 CTRL   bit0 GO (write-1 pulse, self-clearing), bit1 IRQ_EN (R/W), bit2 ABORT (write-1 pulse)
//   3 STATUS bit0 BUSY, bit1 DONE, bit2 ERR, [30:16] words remaining
//     - STATUS writes are W1C on DONE and ERR.
//  Reset values: every register, output and counter = 0, except mem_clken = 1.
//  FSM:
//   - IDLE -> RUN on GO, only when LENGTH != 0 and START+LENGTH <= DEPTH.
//     Computed at ADDR_W+2 bits, no wrap.
//   - Otherwise GO sets ERR and the FSM stays in IDLE.
//   - On GO-accept: cur_addr <= START, remaining <= LENGTH, DONE <= 0, ERR <= 0.
//   - RUN: snk_ready = 1 (combinational from state). Each cycle with snk_valid & snk_ready:
//     - Next cycle: mem_write = mem_chipselect = 1, mem_address = cur_addr,
//       mem_writedata = snk_data, mem_byteenable = 4'hF.
//     - Same cycle: cur_addr += 1 and remaining -= 1.
//     - Write latency is exactly 1 cycle from the handshake. Back-to-back words give
//       one write per cycle.
//   - RUN -> IDLE when the accepted word takes remaining from 1 to 0.
//     - snk_ready drops the following cycle.
//     - DONE sets in the same cycle as the final mem_write.
//   - ABORT in RUN: return to IDLE next cycle and set ERR; DONE stays 0.
//     - A handshake in the ABORT cycle is still written.
//   - When idle: mem_write, mem_chipselect and mem_byteenable = 0. mem_address and
//     mem_writedata hold their last values.
//  Rules:
//   - Writes to START/LENGTH while BUSY are ignored.
//   - GO while BUSY is ignored.
//   - GO and ABORT in the same write: ABORT wins if BUSY, GO wins if IDLE.
//   - A DONE W1C in the same cycle DONE sets: the set wins.
//   - snk_valid while IDLE: no handshake, no RAM write.
//   - ctl_readdata is registered. An unmapped read returns 0.
//   - Async reset mid-RUN: immediate IDLE, outputs go to reset values, transfer discarded.
// TESTING
//  1. START=0x10, LENGTH=4, GO; stream A0..A3 back-to-back -> writes to 0x10..0x13 on 4
//     consecutive cycles, then DONE=1 and BUSY=0.
//  2. LENGTH=3 with snk_valid toggled 1,0,1,0,1 -> exactly 3 writes, each 1 cycle after
//     its handshake, with no write in gap cycles.
//  3. START=25598, LENGTH=3, GO -> ERR=1, BUSY=0, no mem_write. LENGTH=0, GO -> ERR=1.
//  4. LENGTH=8, IRQ_EN=1; ABORT after 5 words -> 5 writes, ERR=1, DONE=0, irq=0,
//     remaining=3.
//  5. IRQ_EN=1, completed transfer -> irq=1. W1C DONE -> irq=0. Write START mid-RUN ->
//     START readback unchanged.
//  6. Assert reset_n low mid-transfer -> all outputs 0 (mem_clken=1) asynchronously, and
//     STATUS=0 after release.

Source files
------------

// File: rtl/mpsoc_memory_stream_loader.sv
// ---------------------------------------------------------------------------
// mpsoc_memory_stream_loader
//
// Fill stage for the MPSoC single-port on-chip RAM. Software programs a start
// word address and a word count through a four-register control slave, then
// pulses GO. Words arriving on the valid/ready sink are written in order to
// consecutive RAM addresses, one cycle after each handshake. DONE (and irq when
// enabled) is raised when the last word is written. ABORT or a rejected GO
// raises ERR instead.
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   ctl_*                 control slave: address/read/write/writedata in,
//                         registered readdata out (valid 1 cycle after read)
//   snk_data/valid/ready  32-bit word stream sink
//   mem_*                 RAM s1-style write port (clken tied high)
//   irq                   level interrupt, DONE & IRQ_EN
//
// Register map (word index)
//   0 START   [ADDR_W-1:0]
//   1 LENGTH  [15:0]
//   2 CTRL    bit0 GO (pulse), bit1 IRQ_EN, bit2 ABORT (pulse)
//   3 STATUS  bit0 BUSY, bit1 DONE (W1C), bit2 ERR (W1C), [30:16] remaining
// ---------------------------------------------------------------------------
module mpsoc_memory_stream_loader #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 25600,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        ctl_address,
    input  logic              ctl_read,
    input  logic              ctl_write,
    input  logic [31:0]       ctl_writedata,
    output logic [31:0]       ctl_readdata,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              irq
);

    // Range check width: two extra bits so START+LENGTH can never wrap.
    localparam int SUM_W = ADDR_W + 2;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [15:0]         length_q, length_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [31:0]         readdata_q, readdata_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic [3:0]          mem_byteenable_q, mem_byteenable_d;
    logic                mem_write_q, mem_write_d;

    logic                busy;
    logic                handshake;
    logic                wr_ctrl;
    logic                go;
    logic                abort;
    logic [SUM_W-1:0]    end_addr;
    logic                range_ok;
    logic                unused_bits;

    assign busy      = (state_q == ST_RUN);
    assign snk_ready = busy;
    assign handshake = snk_valid & busy;
    assign wr_ctrl   = ctl_write & (ctl_address == 2'd2);
    assign go        = wr_ctrl & ctl_writedata[0];
    assign abort     = wr_ctrl & ctl_writedata[2];
    assign end_addr  = SUM_W'(start_q) + SUM_W'(length_q);
    assign range_ok  = (length_q != 16'd0) && (end_addr <= SUM_W'(DEPTH));

    assign ctl_readdata   = readdata_q;
    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_write      = mem_write_q;
    assign mem_chipselect = mem_write_q;
    assign mem_clken      = 1'b1;
    assign irq            = done_q & irq_en_q;

    assign unused_bits = &{1'b0, ctl_writedata[31:16], remaining_q[15]};

    // Next-state logic. Later assignments deliberately override earlier ones:
    // a DONE/ERR set in the same cycle as its W1C clear wins, and ABORT takes
    // priority over normal completion.
    always_comb begin
        state_d          = state_q;
        start_d          = start_q;
        length_d         = length_q;
        irq_en_d         = irq_en_q;
        done_d           = done_q;
        err_d            = err_q;
        cur_addr_d       = cur_addr_q;
        remaining_d      = remaining_q;
        readdata_d       = readdata_q;
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = 4'h0;
        mem_write_d      = 1'b0;

        if (ctl_write) begin
            case (ctl_address)
                2'd0: if (!busy) start_d = ctl_writedata[ADDR_W-1:0];
                2'd1: if (!busy) length_d = ctl_writedata[15:0];
                2'd2: irq_en_d = ctl_writedata[1];
                2'd3: begin
                    if (ctl_writedata[1]) done_d = 1'b0;
                    if (ctl_writedata[2]) err_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (ctl_read) begin
            case (ctl_address)
                2'd0: readdata_d = {{(32-ADDR_W){1'b0}}, start_q};
                2'd1: readdata_d = {16'h0000, length_q};
                2'd2: readdata_d = {30'd0, irq_en_q, 1'b0};
                2'd3: readdata_d = {1'b0, remaining_q[14:0], 13'd0, err_q, done_q, busy};
                default: readdata_d = 32'd0;
            endcase
        end

        // Handshake word goes out on the RAM port next cycle, even during ABORT.
        if (handshake) begin
            mem_write_d      = 1'b1;
            mem_byteenable_d = 4'hF;
            mem_address_d    = cur_addr_q;
            mem_writedata_d  = snk_data;
            cur_addr_d       = cur_addr_q + ADDR_W'(1);
            remaining_d      = remaining_q - 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (range_ok) begin
                        state_d     = ST_RUN;
                        cur_addr_d  = start_q;
                        remaining_d = length_q;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (handshake && remaining_q == 16'd1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            start_q          <= '0;
            length_q         <= '0;
            irq_en_q         <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            cur_addr_q       <= '0;
            remaining_q      <= '0;
            readdata_q       <= '0;
            mem_address_q    <= '0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            mem_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            start_q          <= start_d;
            length_q         <= length_d;
            irq_en_q         <= irq_en_d;
            done_q           <= done_d;
            err_q            <= err_d;
            cur_addr_q       <= cur_addr_d;
            remaining_q      <= remaining_d;
            readdata_q       <= readdata_d;
            mem_address_q    <= mem_address_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_write_q      <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_memory_stream_loader.sv
// Directed bench for mpsoc_memory_stream_loader. Inputs change 1 ns after the
// rising edge; outputs are checked at that same point, after the registers
// have settled.
module tb_mpsoc_memory_stream_loader;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ctl_address;
    logic        ctl_read;
    logic        ctl_write;
    logic [31:0] ctl_writedata;
    logic [31:0] ctl_readdata;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] rd;
    int k;

    localparam logic [4:0] GAP_PATTERN = 5'b10101;

    mpsoc_memory_stream_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctl_address    (ctl_address),
        .ctl_read       (ctl_read),
        .ctl_write      (ctl_write),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        ctl_address   = addr;
        ctl_writedata = data;
        ctl_write     = 1'b1;
        tick();
        ctl_write     = 1'b0;
    endtask

    task automatic ctlRead(input logic [1:0] addr, output logic [31:0] data);
        ctl_address = addr;
        ctl_read    = 1'b1;
        tick();
        ctl_read    = 1'b0;
        data        = ctl_readdata;
    endtask

    task automatic checkWrite(input string tag, input logic [14:0] addr, input logic [31:0] data);
        checkOutput({tag, ".mem_write"}, 32'(mem_write), 32'd1);
        checkOutput({tag, ".mem_chipselect"}, 32'(mem_chipselect), 32'd1);
        checkOutput({tag, ".mem_byteenable"}, 32'(mem_byteenable), 32'hF);
        checkOutput({tag, ".mem_address"}, 32'(mem_address), 32'(addr));
        checkOutput({tag, ".mem_writedata"}, mem_writedata, data);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".mem_write"}, 32'(mem_write), 32'd0);
        checkOutput({tag, ".mem_chipselect"}, 32'(mem_chipselect), 32'd0);
        checkOutput({tag, ".mem_byteenable"}, 32'(mem_byteenable), 32'd0);
        checkOutput({tag, ".mem_address"}, 32'(mem_address), 32'd0);
        checkOutput({tag, ".mem_writedata"}, mem_writedata, 32'd0);
        checkOutput({tag, ".mem_clken"}, 32'(mem_clken), 32'd1);
        checkOutput({tag, ".snk_ready"}, 32'(snk_ready), 32'd0);
        checkOutput({tag, ".irq"}, 32'(irq), 32'd0);
        checkOutput({tag, ".ctl_readdata"}, ctl_readdata, 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        ctl_address   = 2'd0;
        ctl_read      = 1'b0;
        ctl_write     = 1'b0;
        ctl_writedata = 32'd0;
        snk_data      = 32'd0;
        snk_valid     = 1'b0;

        // Reset state
        #3;
        checkResetOutputs("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 1: four back-to-back words to 0x10..0x13
        $display("[TB] step 1: back-to-back transfer");
        applyStimulus(2'd0, 32'h10);
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd2, 32'h1);
        checkOutput("t1.snk_ready_run", 32'(snk_ready), 32'd1);
        ctlRead(2'd3, rd);
        checkOutput("t1.status_busy", rd, 32'h0004_0001);
        for (int i = 0; i < 4; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'hA0 + 32'(i);
            tick();
            checkWrite($sformatf("t1.w%0d", i), 15'(16 + i), 32'hA0 + 32'(i));
        end
        snk_valid = 1'b0;
        checkOutput("t1.snk_ready_drop", 32'(snk_ready), 32'd0);
        tick();
        checkOutput("t1.idle_no_write", 32'(mem_write), 32'd0);
        checkOutput("t1.idle_be", 32'(mem_byteenable), 32'd0);
        checkOutput("t1.addr_hold", 32'(mem_address), 32'h13);
        ctlRead(2'd3, rd);
        checkOutput("t1.status_done", rd, 32'h0000_0002);

        // 2: gapped stream, three words to 0x20..0x22
        $display("[TB] step 2: gapped transfer");
        applyStimulus(2'd0, 32'h20);
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd2, 32'h1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            snk_valid = GAP_PATTERN[4 - i];
            snk_data  = 32'hB0 + 32'(i);
            tick();
            if (GAP_PATTERN[4 - i]) begin
                checkWrite($sformatf("t2.w%0d", k), 15'(32 + k), 32'hB0 + 32'(i));
                k++;
            end else begin
                checkOutput($sformatf("t2.gap%0d", i), 32'(mem_write), 32'd0);
            end
        end
        snk_valid = 1'b0;
        tick();
        checkOutput("t2.after_last", 32'(mem_write), 32'd0);
        ctlRead(2'd3, rd);
        checkOutput("t2.status_done", rd, 32'h0000_0002);

        // 3: out-of-range and zero-length GO are rejected
        $display("[TB] step 3: rejected GO");
        applyStimulus(2'd3, 32'h6);
        ctlRead(2'd3, rd);
        checkOutput("t3.status_cleared", rd, 32'h0);
        applyStimulus(2'd0, 32'd25598);
        applyStimulus(2'd1, 32'd3);
        snk_valid = 1'b1;
        snk_data  = 32'hDEAD;
        applyStimulus(2'd2, 32'h1);
        checkOutput("t3.snk_ready", 32'(snk_ready), 32'd0);
        tick();
        checkOutput("t3.no_write", 32'(mem_write), 32'd0);
        snk_valid = 1'b0;
        ctlRead(2'd3, rd);
        checkOutput("t3.status_err_range", rd, 32'h0000_0004);
        applyStimulus(2'd3, 32'h4);
        applyStimulus(2'd0, 32'd0);
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd2, 32'h1);
        checkOutput("t3.snk_ready_len0", 32'(snk_ready), 32'd0);
        ctlRead(2'd3, rd);
        checkOutput("t3.status_err_len0", rd, 32'h0000_0004);

        // 4: ABORT in the same cycle as the 5th handshake
        $display("[TB] step 4: abort");
        applyStimulus(2'd3, 32'h4);
        applyStimulus(2'd0, 32'h40);
        applyStimulus(2'd1, 32'd8);
        applyStimulus(2'd2, 32'h3);
        for (int i = 0; i < 4; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'hC0 + 32'(i);
            tick();
            checkWrite($sformatf("t4.w%0d", i), 15'(64 + i), 32'hC0 + 32'(i));
        end
        snk_data = 32'hC4;
        applyStimulus(2'd2, 32'h6);
        snk_valid = 1'b0;
        checkWrite("t4.w4", 15'h44, 32'hC4);
        checkOutput("t4.snk_ready", 32'(snk_ready), 32'd0);
        tick();
        checkOutput("t4.no_write", 32'(mem_write), 32'd0);
        ctlRead(2'd3, rd);
        checkOutput("t4.status", rd, 32'h0003_0004);
        checkOutput("t4.irq", 32'(irq), 32'd0);

        // 5: transfer ending exactly at DEPTH, irq, START write ignored while busy
        $display("[TB] step 5: irq and busy write protection");
        applyStimulus(2'd3, 32'h4);
        applyStimulus(2'd0, 32'd25597);
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd2, 32'h3);
        checkOutput("t5.accepted", 32'(snk_ready), 32'd1);
        snk_valid = 1'b1;
        snk_data  = 32'hD0;
        tick();
        checkWrite("t5.w0", 15'd25597, 32'hD0);
        snk_valid = 1'b0;
        applyStimulus(2'd0, 32'h1234);
        checkOutput("t5.gap", 32'(mem_write), 32'd0);
        for (int i = 1; i < 3; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'hD0 + 32'(i);
            tick();
            checkWrite($sformatf("t5.w%0d", i), 15'(25597 + i), 32'hD0 + 32'(i));
        end
        snk_valid = 1'b0;
        checkOutput("t5.irq_set", 32'(irq), 32'd1);
        ctlRead(2'd3, rd);
        checkOutput("t5.status_done", rd, 32'h0000_0002);
        ctlRead(2'd0, rd);
        checkOutput("t5.start_unchanged", rd, 32'd25597);
        ctlRead(2'd2, rd);
        checkOutput("t5.ctrl_readback", rd, 32'h2);
        applyStimulus(2'd3, 32'h2);
        checkOutput("t5.irq_cleared", 32'(irq), 32'd0);

        // 6: asynchronous reset mid-transfer
        $display("[TB] step 6: reset mid-transfer");
        applyStimulus(2'd0, 32'h50);
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd2, 32'h1);
        for (int i = 0; i < 2; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'hE0 + 32'(i);
            tick();
        end
        checkWrite("t6.w1", 15'h51, 32'hE1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("t6.async");
        snk_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        ctlRead(2'd3, rd);
        checkOutput("t6.status_zero", rd, 32'h0);
        ctlRead(2'd0, rd);
        checkOutput("t6.start_zero", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
